uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_receiver.sv | 191 +++++++++++++++++++
 tb/tb_uart_receiver.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: 8-bit asynchronous serial receiver (start bit, 8 data bits LSB first,
// optional even parity bit, one stop bit) with mid-bit sampling on a synchronized line.
// Define UART_RX_PARITY_EN to build the even-parity variant (start+8+parity+stop);
// without it frames are 8N1 and parity_error is tied low.
module uart_receiver #(
   parameter int CLK_FREQ = 100000000,
   parameter int BAUD     = 9600
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] dataout,
   output logic       data_valid,
   output logic       framing_error,
   output logic       parity_error,
   output logic       busy
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   // Too few clocks per bit leaves no room for a meaningful mid-bit sample.
   generate
      if (CLKS_PER_BIT < 4) begin : g_bad_rate
         $error("uart_receiver: CLK_FREQ/BAUD must be at least 4");
      end
   endgenerate

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic [2:0]       index_reg, index_next;
   logic [7:0]       bits_reg, bits_next;
   logic [7:0]       dataout_reg, dataout_next;
   logic             valid_reg, valid_next;
   logic             ferr_reg, ferr_next;
`ifdef UART_RX_PARITY_EN
   logic             perr_reg, perr_next;
   logic             mismatch_reg, mismatch_next;
`endif

   logic rx_meta, rx_s, rx_prev;

   // Two-flop synchronizer plus one history flop for falling-edge detection; idle-high reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   // State register and all datapath/strobe registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= IDLE;
         count_reg    <= '0;
         index_reg    <= 3'd0;
         bits_reg     <= 8'h00;
         dataout_reg  <= 8'h00;
         valid_reg    <= 1'b0;
         ferr_reg     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_reg     <= 1'b0;
         mismatch_reg <= 1'b0;
`endif
      end else begin
         state_reg    <= state_next;
         count_reg    <= count_next;
         index_reg    <= index_next;
         bits_reg     <= bits_next;
         dataout_reg  <= dataout_next;
         valid_reg    <= valid_next;
         ferr_reg     <= ferr_next;
`ifdef UART_RX_PARITY_EN
         perr_reg     <= perr_next;
         mismatch_reg <= mismatch_next;
`endif
      end
   end

   // Next-state and datapath logic; strobes default low so each lasts a single cycle.
   always_comb begin
      state_next    = state_reg;
      count_next    = count_reg;
      index_next    = index_reg;
      bits_next     = bits_reg;
      dataout_next  = dataout_reg;
      valid_next    = 1'b0;
      ferr_next     = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_next     = 1'b0;
      mismatch_next = mismatch_reg;
`endif
      case (state_reg)
         IDLE: begin
            count_next = '0;
            if (rx_prev && !rx_s) begin
               state_next = START;
            end
         end
         START: begin
            if (count_reg == CNT_HALF) begin
               count_next = '0;
               if (!rx_s) begin
                  state_next = DATA;
                  index_next = 3'd0;
`ifdef UART_RX_PARITY_EN
                  mismatch_next = 1'b0;
`endif
               end else begin
                  // Line went back high before mid start bit: treat as noise.
                  state_next = IDLE;
               end
            end else begin
               count_next = count_reg + 1'b1;
            end
         end
         DATA: begin
            if (count_reg == CNT_LAST) begin
               count_next           = '0;
               bits_next[index_reg] = rx_s;
               index_next           = index_reg + 3'd1;
               if (index_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_next = PARITY;
`else
                  state_next = STOP;
`endif
               end
            end else begin
               count_next = count_reg + 1'b1;
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (count_reg == CNT_LAST) begin
               count_next    = '0;
               mismatch_next = rx_s ^ (^bits_reg);
               state_next    = STOP;
            end else begin
               count_next = count_reg + 1'b1;
            end
         end
`endif
         STOP: begin
            if (count_reg == CNT_LAST) begin
               count_next = '0;
               state_next = IDLE;
               if (rx_s) begin
                  dataout_next = bits_reg;
                  valid_next   = 1'b1;
`ifdef UART_RX_PARITY_EN
                  perr_next    = mismatch_reg;
`endif
               end else begin
                  ferr_next = 1'b1;
               end
            end else begin
               count_next = count_reg + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            count_next = '0;
         end
      endcase
   end

   assign dataout       = dataout_reg;
   assign data_valid    = valid_reg;
   assign framing_error = ferr_reg;
   assign busy          = (state_reg != IDLE);
`ifdef UART_RX_PARITY_EN
   assign parity_error  = perr_reg;
`else
   assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: scoreboard bench for uart_receiver at CLKS_PER_BIT=10.
// Builds for both the 8N1 and the even-parity variant (UART_RX_PARITY_EN).
module tb_uart_receiver;

   localparam int CLK_FREQ = 1000000;
   localparam int BAUD     = 100000;
   localparam int CPB      = 10;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN     = 1'b1;
   localparam int FRAME_BITS = 11;
`else
   localparam bit PAR_EN     = 1'b0;
   localparam int FRAME_BITS = 10;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       rx;
   logic [7:0] dataout;
   logic       data_valid;
   logic       framing_error;
   logic       parity_error;
   logic       busy;

   always #5 clk = ~clk;

   uart_receiver #(
      .CLK_FREQ(CLK_FREQ),
      .BAUD    (BAUD)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rx           (rx),
      .dataout      (dataout),
      .data_valid   (data_valid),
      .framing_error(framing_error),
      .parity_error (parity_error),
      .busy         (busy)
   );

   typedef struct {
      logic       dv;
      logic       fe;
      logic       pe;
      logic [7:0] d;
      int         cyc;
   } event_t;

   event_t     exp_q[$];
   event_t     obs_q[$];
   int         checks = 0;
   int         errors = 0;
   int         cycle  = 0;
   logic [7:0] last_good = 8'h00;

   always @(posedge clk) cycle <= cycle + 1;

   // Monitor: every strobe cycle becomes one observed event.
   always @(negedge clk) begin
      if (data_valid === 1'b1 || framing_error === 1'b1 || parity_error === 1'b1) begin
         obs_q.push_back(event_t'{data_valid, framing_error, parity_error, dataout, cycle});
         $display("t=%0t strobe dv=%b fe=%b pe=%b dataout=%h", $time, data_valid,
                  framing_error, parity_error, dataout);
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required to have finished", $time);
      $fatal(1, "watchdog");
   end

   // Drive one frame and push the result the receiver should report for it.
   task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
      event_t e;
      e.cyc = cycle;
      if (stop) begin
         e.dv = 1'b1; e.fe = 1'b0; e.d = d;
         e.pe = PAR_EN ? (par != ^d) : 1'b0;
         last_good = d;
      end else begin
         e.dv = 1'b0; e.fe = 1'b1; e.pe = 1'b0; e.d = last_good;
      end
      exp_q.push_back(e);
      $display("t=%0t send byte=%h stop=%b par=%b", $time, d, stop, par);
      rx = 1'b0;
      repeat (CPB) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         repeat (CPB) @(posedge clk);
         #1;
      end
      if (PAR_EN) begin
         rx = par;
         repeat (CPB) @(posedge clk);
         #1;
      end
      rx = stop;
      repeat (CPB) @(posedge clk);
      #1;
      rx = 1'b1;
   endtask

   // Bounded wait until as many strobes as expectations have arrived, then settle.
   task automatic wait_results(input int budget);
      for (int i = 0; i < budget && obs_q.size() < exp_q.size(); i++) @(posedge clk);
      repeat (2 * CPB) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      rx    = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy, data_valid, framing_error, parity_error, dataout} !== 12'h000) begin
         errors++;
         $display("FAIL reset_state: busy/dv/fe/pe/dataout=%b/%b/%b/%b/%h, required 0/0/0/0/00",
                  busy, data_valid, framing_error, parity_error, dataout);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      last_good = 8'h00;
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      event_t e, o;
      send_frame(8'hA5, 1'b1, ^8'hA5);
      wait_results(300);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL basic_missing: no strobe seen, required dv=%b d=%h", e.dv, e.d);
         end else begin
            o = obs_q.pop_front();
            if (o.dv !== e.dv || o.fe !== e.fe || o.pe !== e.pe || o.d !== e.d) begin
               errors++;
               $display("FAIL basic: got dv=%b fe=%b pe=%b d=%h, required dv=%b fe=%b pe=%b d=%h",
                        o.dv, o.fe, o.pe, o.d, e.dv, e.fe, e.pe, e.d);
            end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL basic_extra: %0d extra strobes, required 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_glitch();
      rx = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rx = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL glitch_busy_high: busy=%b, required 1", busy);
      end
      repeat (3 * CPB) @(posedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL glitch_busy_low: busy=%b, required 0", busy);
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL glitch_strobe: %0d strobes, required 0", obs_q.size());
         obs_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_framing();
      event_t e, o;
      send_frame(8'h3C, 1'b0, ^8'h3C);
      wait_results(300);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL framing_missing: no strobe seen, required fe=1 d=%h", e.d);
         end else begin
            o = obs_q.pop_front();
            if (o.dv !== e.dv || o.fe !== e.fe || o.pe !== e.pe || o.d !== e.d) begin
               errors++;
               $display("FAIL framing: got dv=%b fe=%b pe=%b d=%h, required dv=%b fe=%b pe=%b d=%h",
                        o.dv, o.fe, o.pe, o.d, e.dv, e.fe, e.pe, e.d);
            end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL framing_extra: %0d extra strobes, required 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   // Wrong parity then correct parity; the 8N1 build must report parity_error=0 for both.
   task automatic test_parity();
      event_t e, o;
      send_frame(8'h07, 1'b1, 1'b0);
      send_frame(8'h07, 1'b1, 1'b1);
      wait_results(400);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL parity_missing: no strobe seen, required pe=%b d=%h", e.pe, e.d);
         end else begin
            o = obs_q.pop_front();
            if (o.dv !== e.dv || o.fe !== e.fe || o.pe !== e.pe || o.d !== e.d) begin
               errors++;
               $display("FAIL parity: got dv=%b fe=%b pe=%b d=%h, required dv=%b fe=%b pe=%b d=%h",
                        o.dv, o.fe, o.pe, o.d, e.dv, e.fe, e.pe, e.d);
            end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL parity_extra: %0d extra strobes, required 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_patterns();
      event_t e, o;
      logic [7:0] pats [5];
      pats = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h5A};
      for (int i = 0; i < 5; i++) begin
         send_frame(pats[i], 1'b1, ^pats[i]);
         repeat (3) @(posedge clk);
         #1;
      end
      wait_results(600);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL pattern_missing: no strobe seen, required d=%h", e.d);
         end else begin
            o = obs_q.pop_front();
            if (o.dv !== e.dv || o.fe !== e.fe || o.pe !== e.pe || o.d !== e.d) begin
               errors++;
               $display("FAIL pattern: got dv=%b fe=%b pe=%b d=%h, required dv=%b fe=%b pe=%b d=%h",
                        o.dv, o.fe, o.pe, o.d, e.dv, e.fe, e.pe, e.d);
            end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL pattern_extra: %0d extra strobes, required 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_back_to_back();
      event_t e, o;
      int cyc_seen [2];
      int n = 0;
      send_frame(8'h55, 1'b1, ^8'h55);
      send_frame(8'hAA, 1'b1, ^8'hAA);
      wait_results(400);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL b2b_missing: no strobe seen, required d=%h", e.d);
         end else begin
            o = obs_q.pop_front();
            if (n < 2) cyc_seen[n] = o.cyc;
            n++;
            if (o.dv !== e.dv || o.fe !== e.fe || o.pe !== e.pe || o.d !== e.d) begin
               errors++;
               $display("FAIL b2b: got dv=%b fe=%b pe=%b d=%h, required dv=%b fe=%b pe=%b d=%h",
                        o.dv, o.fe, o.pe, o.d, e.dv, e.fe, e.pe, e.d);
            end
         end
      end
      checks++;
      if (n != 2 || cyc_seen[1] - cyc_seen[0] < FRAME_BITS * CPB - 2 ||
          cyc_seen[1] - cyc_seen[0] > FRAME_BITS * CPB + 2) begin
         errors++;
         $display("FAIL b2b_spacing: %0d strobes %0d cycles apart, required 2 strobes %0d+-2 apart",
                  n, (n == 2) ? cyc_seen[1] - cyc_seen[0] : 0, FRAME_BITS * CPB);
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_extra: %0d extra strobes, required 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_reset_midframe();
      event_t e, o;
      $display("t=%0t send byte=ff aborted by reset at data bit 4", $time);
      rx = 1'b0;
      repeat (CPB) @(posedge clk);
      #1;
      rx = 1'b1;
      repeat (4 * CPB + CPB / 2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, data_valid, framing_error, parity_error, dataout} !== 12'h000) begin
         errors++;
         $display("FAIL midreset_state: busy/dv/fe/pe/dataout=%b/%b/%b/%b/%h, required 0/0/0/0/00",
                  busy, data_valid, framing_error, parity_error, dataout);
      end
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      last_good = 8'h00;
      repeat (FRAME_BITS * CPB) @(posedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || obs_q.size() != 0) begin
         errors++;
         $display("FAIL midreset_abort: busy=%b strobes=%0d, required busy=0 strobes=0",
                  busy, obs_q.size());
         obs_q.delete();
      end
      @(posedge clk);
      #1;
      send_frame(8'h12, 1'b1, ^8'h12);
      wait_results(300);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL midreset_missing: no strobe seen, required d=%h", e.d);
         end else begin
            o = obs_q.pop_front();
            if (o.dv !== e.dv || o.fe !== e.fe || o.pe !== e.pe || o.d !== e.d) begin
               errors++;
               $display("FAIL midreset_next: got dv=%b fe=%b pe=%b d=%h, required dv=%b fe=%b pe=%b d=%h",
                        o.dv, o.fe, o.pe, o.d, e.dv, e.fe, e.pe, e.d);
            end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL midreset_extra: %0d extra strobes, required 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_glitch();
      test_framing();
      test_parity();
      test_patterns();
      test_back_to_back();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
